rtc_i2c_responder: RTL
======================

# rtc_i2c_responder

I2C target that emulates a DS1307-compatible real-time clock on the RTC_SCL/RTC_SDA bus. It is the responder counterpart to `rtc_controller`. It serves as a board-level stand-in on boards without the RTC chip and as the bus model for controller verification. Time keeping is driven by an external 1 Hz tick and uses BCD calendar arithmetic. The block answers byte-oriented pointer-write / data-read/write transactions at I2C address 7'h68.

## Interface
- `I2C_ADDR`, 7'h68, 7-bit target address.
- `HOLD_CYC`, 4, clk14 cycles from detected SCL fall to SDA output change (must be ≥1).
- `clk14  input  1  14 MHz system clock; all logic on rising edge.`
- `reset_n  input  1  reset; one clock; reset is synchronous and active-low.`
- `scl_i  input  1  raw SCL pin level (asynchronous).`
- `sda_i  input  1  raw SDA pin level (asynchronous).`
- `sda_o  output  1  SDA drive value; constant 0 (open-drain).`
- `sda_oen  output  1  SDA output enable, active-low; 0 pulls SDA low.`
- `tick_1hz  input  1  single-cycle pulse advancing time by one second.`
- `busy  output  1  high from START with address match until STOP or NACK-terminated read.`

## Operation
- Inputs pass through a 2-FF synchronizer, then a 1-FF edge detector.
  - START is SDA falling while SCL is high; STOP is SDA rising while SCL is high.
  - Bits are sampled on the detected SCL rise.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
  - Any START (including repeated) goes to ADDR with the bit counter cleared.
  - Any STOP goes to IDLE and releases SDA.
- ADDR: shift 8 bits MSB-first.
  - On mismatch, go to IDLE and ignore the bus until the next START.
  - On match, go to ADDR_ACK and drive ACK.
  - If R/W=1, take a snapshot of registers 0x00–0x06 into a shadow copy, then go to RD_DATA. Otherwise go to PTR.
- PTR: the received byte loads the 6-bit pointer; go to PTR_ACK (ACK), then WR_DATA.
- WR_DATA: the received byte is written to reg[pointer] at the ACK bit; ACK is always driven, then the pointer increments.
- RD_DATA: shift the shadow byte (or 0x00) MSB-first, then go to RD_ACK and release SDA.
  - On master ACK, increment the pointer and go to RD_DATA.
  - On master NACK, go to IDLE.
- Register map (BCD, 24 h only):
  - 0x00 sec: bit7 = CH; CH=1 halts ticking.
  - 0x01 min, 0x02 hour (bit6 forced 0 on write), 0x03 weekday 1–7, 0x04 day, 0x05 month, 0x06 year 00–99.
  - 0x07–0x3F read 0x00; writes to them are ignored.
- Pointer is 6-bit and wraps 0x3F→0x00.
- Reset values: sec 0x00, min 0x00, hour 0x00, weekday 0x01, day 0x01, month 0x01, year 0x00.
  - Outputs at reset: sda_oen=1, sda_o=0, busy=0; FSM in IDLE; pointer 0.
- tick_1hz with CH=0 increments sec, with the carry chain:
  - sec 59→00 carries into min; min 59→00 carries into hour; hour 23→00.
  - The hour-23→00 carry increments weekday (7→1) and day.
  - day rolls past the month length (Apr/Jun/Sep/Nov = 30; Feb = 29 if year%4==0, else 28) to 01 and increments month.
  - month 12→01 increments year; year 99→00.
- Simultaneous tick and register write: the write wins in that cycle. The tick is held in a pending flag and applied the next cycle, including to the freshly written value.
- A second tick arriving while one is pending is dropped; this cannot occur at 1 Hz.
- Reset mid-transaction: SDA is released within the reset cycle, the FSM goes to IDLE and registers return to their reset values.

## Timing
- Pin-to-event latency is 3 clk14 cycles: 2 sync stages plus 1 edge-detect stage.
- sda_oen changes exactly HOLD_CYC cycles after the detected SCL fall that ends the previous bit. This applies to ACK assertion, ACK release and every read data bit.
- A write lands in the register on the detected SCL rise of the 8th data bit. It is visible to a subsequent read transaction's snapshot.
- The snapshot is taken in the cycle the address byte with R/W=1 is accepted. Ticks after that point do not affect the bytes read in that transaction.
- No clock stretching: SCL is never driven.

## Structure
- Package `rtc_pkg` holds:
  - I2C_ADDR default and register index localparams (REG_SEC..REG_YEAR).
  - Reset value constants and the FSM state enum.
- Sub-module `bcd_calendar` holds the seven registers and implements tick increment, month-length/leap logic and the write port.
- The I2C FSM, synchronizer, shadow copy and pointer live in `rtc_i2c_responder`.

## Test plan
- Write sequence 0xD0, ptr 0x00, data 0x59,0x59,0x23,0x07,0x31,0x12,0x99, then a tick → read back 00,00,00,01,01,01,00; every byte is ACKed.
- Read with address 0xA0 → no ACK (SDA high on the 9th bit); busy stays 0; the bus is ignored until the next START.
- Set day=0x28, month=0x02, year=0x24, hour 23:59:59, then tick → day 0x29. Repeat with year=0x23 → day 0x01, month 0x03.
- Tick pulse in the same cycle as a write of 0x10 to sec → sec reads 0x11. Write sec=0x80 (CH set), then 5 ticks → sec stays 0x80.
- Read starting at ptr 0x3E for 4 bytes → 0x00, 0x00, then sec, min (pointer wrap). A tick during the read does not alter the returned bytes.
- Assert reset_n=0 while the responder drives ACK low → sda_oen=1 on the next clk14 edge, busy=0, registers at reset values.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared constants, FSM state type and BCD helpers for the DS1307-style I2C responder.
package rtc_pkg;

  localparam logic [6:0] I2C_ADDR_DEFAULT = 7'h68;

  localparam logic [2:0] REG_SEC   = 3'd0;
  localparam logic [2:0] REG_MIN   = 3'd1;
  localparam logic [2:0] REG_HOUR  = 3'd2;
  localparam logic [2:0] REG_WDAY  = 3'd3;
  localparam logic [2:0] REG_DAY   = 3'd4;
  localparam logic [2:0] REG_MONTH = 3'd5;
  localparam logic [2:0] REG_YEAR  = 3'd6;

  localparam logic [7:0] RST_SEC   = 8'h00;
  localparam logic [7:0] RST_MIN   = 8'h00;
  localparam logic [7:0] RST_HOUR  = 8'h00;
  localparam logic [7:0] RST_WDAY  = 8'h01;
  localparam logic [7:0] RST_DAY   = 8'h01;
  localparam logic [7:0] RST_MONTH = 8'h01;
  localparam logic [7:0] RST_YEAR  = 8'h00;

  localparam logic [6:0][7:0] RST_REGS =
    {RST_YEAR, RST_MONTH, RST_DAY, RST_WDAY, RST_HOUR, RST_MIN, RST_SEC};

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK
  } i2c_state_t;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction

  // Year is BCD: (10*t + u) mod 4 == (2*t + u) mod 4, so parity of t picks the unit set.
  function automatic logic [7:0] month_len(input logic [7:0] month, input logic [7:0] year);
    logic leap;
    leap = year[4] ? (year[3:0] == 4'd2 || year[3:0] == 4'd6)
                   : (year[3:0] == 4'd0 || year[3:0] == 4'd4 || year[3:0] == 4'd8);
    if (month == 8'h04 || month == 8'h06 || month == 8'h09 || month == 8'h11)
      return 8'h30;
    else if (month == 8'h02)
      return leap ? 8'h29 : 8'h28;
    else
      return 8'h31;
  endfunction

endpackage

// File: rtl/bcd_calendar.sv
// Seven BCD time/date registers with 1 Hz carry chain and a single-byte write port.
module bcd_calendar
  import rtc_pkg::*;
(
  input  logic            clk14,
  input  logic            reset_n,
  input  logic            tick_1hz,
  input  logic            wr_en,
  input  logic [2:0]      wr_idx,
  input  logic [7:0]      wr_data,
  output logic [6:0][7:0] regs
);

  logic [6:0][7:0] r, nxt;
  logic            tick_pend;

  assign regs = r;

  always_comb begin
    nxt = r;
    if (!r[REG_SEC][7]) begin
      if (r[REG_SEC] >= 8'h59) begin
        nxt[REG_SEC] = 8'h00;
        if (r[REG_MIN] >= 8'h59) begin
          nxt[REG_MIN] = 8'h00;
          if (r[REG_HOUR] >= 8'h23) begin
            nxt[REG_HOUR] = 8'h00;
            nxt[REG_WDAY] = (r[REG_WDAY] >= 8'h07) ? 8'h01 : bcd_inc(r[REG_WDAY]);
            if (r[REG_DAY] >= month_len(r[REG_MONTH], r[REG_YEAR])) begin
              nxt[REG_DAY] = 8'h01;
              if (r[REG_MONTH] >= 8'h12) begin
                nxt[REG_MONTH] = 8'h01;
                nxt[REG_YEAR]  = (r[REG_YEAR] >= 8'h99) ? 8'h00 : bcd_inc(r[REG_YEAR]);
              end else begin
                nxt[REG_MONTH] = bcd_inc(r[REG_MONTH]);
              end
            end else begin
              nxt[REG_DAY] = bcd_inc(r[REG_DAY]);
            end
          end else begin
            nxt[REG_HOUR] = bcd_inc(r[REG_HOUR]);
          end
        end else begin
          nxt[REG_MIN] = bcd_inc(r[REG_MIN]);
        end
      end else begin
        nxt[REG_SEC] = bcd_inc(r[REG_SEC]);
      end
    end
  end

  // A write takes the cycle; a coincident tick is deferred one cycle and applied on top of it.
  always_ff @(posedge clk14) begin
    if (!reset_n) begin
      r         <= RST_REGS;
      tick_pend <= 1'b0;
    end else if (wr_en) begin
      r[wr_idx] <= (wr_idx == REG_HOUR) ? (wr_data & 8'hBF) : wr_data;
      if (tick_1hz) tick_pend <= 1'b1;
    end else if (tick_1hz || tick_pend) begin
      r         <= nxt;
      tick_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/rtc_i2c_responder.sv
// I2C target at I2C_ADDR emulating a DS1307 register file over a synchronised SCL/SDA pair.
module rtc_i2c_responder
  import rtc_pkg::*;
#(
  parameter logic [6:0]  I2C_ADDR = I2C_ADDR_DEFAULT,
  parameter int unsigned HOLD_CYC = 4
) (
  input  logic clk14,
  input  logic reset_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic sda_oen,
  input  logic tick_1hz,
  output logic busy
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYC);

  logic scl_m, scl_s, scl_d, sda_m, sda_s, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  i2c_state_t      state, state_n;
  logic [2:0]      bit_cnt;
  logic [6:0]      shreg;
  logic [5:0]      ptr;
  logic [6:0][7:0] shadow, cal_regs;
  logic [7:0]      hold_cnt, rx_byte, rd_byte;
  logic            drive_pend, drive_val, byte_done, addr_hit, wr_en;

  assign sda_o = 1'b0;

  always_ff @(posedge clk14) begin
    if (!reset_n) begin
      {scl_m, scl_s, scl_d, sda_m, sda_s, sda_d} <= '1;
    end else begin
      {scl_m, scl_s, scl_d} <= {scl_i, scl_m, scl_s};
      {sda_m, sda_s, sda_d} <= {sda_i, sda_m, sda_s};
    end
  end

  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  assign rx_byte   = {shreg, sda_s};
  assign byte_done = scl_rise && (bit_cnt == 3'd7);
  assign addr_hit  = (shreg == I2C_ADDR);
  assign rd_byte   = (ptr < 6'd7) ? shadow[ptr[2:0]] : 8'h00;
  assign wr_en     = byte_done && (state == ST_WR_DATA) && (ptr < 6'd7);

  bcd_calendar u_cal (
    .clk14    (clk14),
    .reset_n  (reset_n),
    .tick_1hz (tick_1hz),
    .wr_en    (wr_en),
    .wr_idx   (ptr[2:0]),
    .wr_data  (rx_byte),
    .regs     (cal_regs)
  );

  always_ff @(posedge clk14) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (start_det) begin
      state_n = ST_ADDR;
    end else if (stop_det) begin
      state_n = ST_IDLE;
    end else if (scl_rise) begin
      case (state)
        ST_ADDR:     if (byte_done) state_n = addr_hit ? ST_ADDR_ACK : ST_IDLE;
        ST_ADDR_ACK: state_n = shreg[0] ? ST_RD_DATA : ST_PTR;
        ST_PTR:      if (byte_done) state_n = ST_PTR_ACK;
        ST_PTR_ACK:  state_n = ST_WR_DATA;
        ST_WR_DATA:  if (byte_done) state_n = ST_WR_ACK;
        ST_WR_ACK:   state_n = ST_WR_DATA;
        ST_RD_DATA:  if (byte_done) state_n = ST_RD_ACK;
        ST_RD_ACK:   state_n = sda_s ? ST_IDLE : ST_RD_DATA;
        default:     ;
      endcase
    end
  end

  // SDA level for the bit that begins at the next SCL fall, judged from the state at that fall.
  always_comb begin
    drive_val = 1'b1;
    case (state)
      ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: drive_val = 1'b0;
      ST_RD_DATA: drive_val = rd_byte[3'd7 - bit_cnt];
      default:    ;
    endcase
  end

  always_ff @(posedge clk14) begin
    if (!reset_n) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      ptr        <= '0;
      shadow     <= RST_REGS;
      busy       <= 1'b0;
      sda_oen    <= 1'b1;
      hold_cnt   <= '0;
      drive_pend <= 1'b1;
    end else if (start_det) begin
      bit_cnt <= '0;
    end else if (stop_det) begin
      bit_cnt  <= '0;
      busy     <= 1'b0;
      sda_oen  <= 1'b1;
      hold_cnt <= '0;
    end else begin
      if (scl_rise) begin
        case (state)
          ST_ADDR: begin
            shreg   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              busy <= addr_hit;
              if (addr_hit && sda_s) shadow <= cal_regs;
            end
          end
          ST_PTR: begin
            shreg   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) ptr <= rx_byte[5:0];
          end
          ST_WR_DATA: begin
            shreg   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
          end
          ST_WR_ACK:  ptr <= ptr + 6'd1;
          ST_RD_DATA: bit_cnt <= bit_cnt + 3'd1;
          ST_RD_ACK: begin
            if (sda_s) busy <= 1'b0;
            else       ptr  <= ptr + 6'd1;
          end
          default: ;
        endcase
      end
      if (scl_fall) begin
        hold_cnt   <= HOLD_LOAD;
        drive_pend <= drive_val;
      end else if (hold_cnt != 8'd0) begin
        hold_cnt <= hold_cnt - 8'd1;
        if (hold_cnt == 8'd1) sda_oen <= drive_pend;
      end
    end
  end

endmodule
